// File: rtl/route_table_arbiter.sv
// rtl/route_table_arbiter.sv - round-robin/locking arbiter for the shared routing-table BRAM
// Optional statistics counters are enabled with the ROUTE_ARB_STATS_EN macro.
module route_table_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        rd_req,
    input  logic [NREQ*ADDR_W-1:0] rd_addr,
    input  logic [NREQ-1:0]        rd_lock,
    output logic [NREQ-1:0]        rd_gnt,
    output logic [NREQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ack,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
`ifdef ROUTE_ARB_STATS_EN
    ,
    output logic [15:0]            stat_wr_stall,
    output logic [15:0]            stat_forced_rel
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [NREQ-1:0]  tag_q [MEM_LAT];

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  rr_cand;
    logic [PTR_W-1:0]  rr_sel;
    logic              rr_found;
    logic              forced_rel;

    for (genvar g = 0; g < NREQ; g++) begin : g_addr
        assign addr_arr[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // First requester strictly after the last granted one, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            rr_cand = PTR_W'((int'(rr_ptr_q) + off) % NREQ);
            if (!rr_found && rd_req[rr_cand]) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        wr_ack      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        forced_rel  = 1'b0;
        if (resetn) begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        wr_ack    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr;
                        mem_wdata = wr_data;
                    end else if (rr_found) begin
                        gnt[rr_sel] = 1'b1;
                        mem_en      = 1'b1;
                        mem_addr    = addr_arr[rr_sel];
                        rr_ptr_d    = rr_sel;
                        if (rd_lock[rr_sel] && (MAX_BURST > 1)) begin
                            state_d     = ST_OWNED;
                            owner_d     = rr_sel;
                            burst_cnt_d = CNT_W'(1);
                        end
                    end
                end
                ST_OWNED: begin
                    // An idle owner keeps the table; writes and other readers wait.
                    if (rd_req[owner_q]) begin
                        gnt[owner_q] = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = addr_arr[owner_q];
                        rr_ptr_d     = owner_q;
                        burst_cnt_d  = burst_cnt_q + CNT_W'(1);
                        if (!rd_lock[owner_q] || (int'(burst_cnt_q) + 1 == MAX_BURST)) begin
                            state_d     = ST_IDLE;
                            burst_cnt_d = '0;
                            forced_rel  = rd_lock[owner_q];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= PTR_W'(NREQ - 1);
            burst_cnt_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tag_q[0]    <= gnt;
            for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign rd_gnt   = gnt;
    assign rd_valid = tag_q[MEM_LAT-1];
    assign rd_data  = resetn ? mem_rdata : '0;

`ifdef ROUTE_ARB_STATS_EN
    logic [15:0] wr_stall_q, forced_rel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_stall_q   <= '0;
            forced_rel_q <= '0;
        end else begin
            if (wr_req && !wr_ack && (wr_stall_q != 16'hFFFF)) wr_stall_q <= wr_stall_q + 16'd1;
            if (forced_rel && (forced_rel_q != 16'hFFFF)) forced_rel_q <= forced_rel_q + 16'd1;
        end
    end

    assign stat_wr_stall   = wr_stall_q;
    assign stat_forced_rel = forced_rel_q;
`endif

endmodule
